// File: rtl/key_input_pio.sv
// rtl/key_input_pio.sv - pushbutton input PIO with edge capture, irq mask and optional debounce (KEY_PIO_DEBOUNCE_EN)
module key_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    // Two-flop synchronizer; resets to released (1) so no press is seen at reset exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync      <= '1;
        end else begin
            sync_meta <= in_port;
            sync      <= sync_meta;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] count [WIDTH];
    logic          unused_ok;

    assign unused_ok = ^writedata;

    // Per-bit stability counter: clean follows sync only after DEBOUNCE_CYCLES mismatching cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == clean[i]) begin
                    count[i] <= '0;
                end else if (count[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    clean[i] <= sync[i];
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end
`else
    logic unused_ok;

    // Debounce parameter and upper write bits have no function in this build
    assign unused_ok = (^writedata) ^ (DEBOUNCE_CYCLES == 0);

    assign clean = sync;
`endif

    // Previous clean value for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_d <= '1;
        end else begin
            clean_d <= clean;
        end
    end

    assign press      = clean_d & ~clean;
    assign wr_en      = chipselect & ~write_n;
    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, written from the low WIDTH bits only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-1-to-clear, with a same-cycle press winning over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clear_bits) | press;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    // Zero-latency read mux, zero-extended above WIDTH
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = clean;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_key_input_pio.sv
// tb/tb_key_input_pio.sv - directed self-checking bench for key_input_pio
module tb_key_input_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    key_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        step(3);
        chk_reg("rst_data", 2'd0, 32'h0000_000F);
        chk_reg("rst_rsvd", 2'd1, 32'h0);
        chk_reg("rst_mask", 2'd2, 32'h0);
        chk_reg("rst_edge", 2'd3, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        reset_n = 1'b1;
        step(4);

        // Writes to data and reserved registers are ignored
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        step(1);
        chk_reg("ro_rsvd", 2'd1, 32'h0);
        chk_reg("ro_mask", 2'd2, 32'h0);
        chk_reg("ro_edge", 2'd3, 32'h0);
        chk_reg("ro_data", 2'd0, 32'h0000_000F);

`ifndef KEY_PIO_DEBOUNCE_EN
        // Press bit 2: data after 2 cycles, edge_capture after 3, irq masked
        in_port = 4'hB;
        step(1);
        chk_reg("lat1_data", 2'd0, 32'h0000_000F);
        step(1);
        chk_reg("lat2_data", 2'd0, 32'h0000_000B);
        chk_reg("lat2_edge", 2'd3, 32'h0);
        step(1);
        chk_reg("lat3_edge", 2'd3, 32'h0000_0004);
        check("lat3_irq", {31'b0, irq}, 32'h0);
        step(1);
        check("lat4_irq_masked", {31'b0, irq}, 32'h0);
        in_port = 4'hF;
        step(4);
        chk_reg("release_no_edge", 2'd3, 32'h0000_0004);
        wr(2'd3, 32'h0000_0004);
        chk_reg("w1c_edge", 2'd3, 32'h0);

        // Mask bit 2 (upper write bits ignored), press and clear with irq tracking
        wr(2'd2, 32'hFFFF_FFF4);
        chk_reg("mask_rd", 2'd2, 32'h0000_0004);
        in_port = 4'hB;
        step(3);
        chk_reg("irq_edge", 2'd3, 32'h0000_0004);
        check("irq_pre", {31'b0, irq}, 32'h0);
        step(1);
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h0000_0004);
        chk_reg("irq_clr_edge", 2'd3, 32'h0);
        check("irq_clr_lag", {31'b0, irq}, 32'h1);
        step(1);
        check("irq_clr", {31'b0, irq}, 32'h0);
        in_port = 4'hF;
        step(4);

        // Press on bit 0 coincident with clearing all bits: set wins, bit 3 cleared
        in_port = 4'h7;
        step(4);
        chk_reg("pre_b3", 2'd3, 32'h0000_0008);
        in_port = 4'hF;
        step(3);
        in_port = 4'hE;
        step(2);
        wr(2'd3, 32'h0000_000F);
        chk_reg("set_prio", 2'd3, 32'h0000_0001);
        in_port = 4'hF;
        step(3);

        // Build edge_capture=3, mask=F, then reset with bit 2 low
        in_port = 4'hD;
        step(4);
        in_port = 4'hF;
        step(3);
        wr(2'd2, 32'h0000_000F);
        step(1);
        chk_reg("pre_rst_edge", 2'd3, 32'h0000_0003);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        in_port = 4'hB;
        step(1);
        reset_n = 1'b0;
        #1;
        chk_reg("mid_rst_data", 2'd0, 32'h0000_000F);
        chk_reg("mid_rst_mask", 2'd2, 32'h0);
        chk_reg("mid_rst_edge", 2'd3, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        step(3);
        chk_reg("mid_rst_data2", 2'd0, 32'h0000_000F);
        reset_n = 1'b1;
        step(1);
        chk_reg("post_rst_d1", 2'd0, 32'h0000_000F);
        step(1);
        chk_reg("post_rst_d2", 2'd0, 32'h0000_000B);
        step(1);
        chk_reg("post_rst_edge", 2'd3, 32'h0000_0004);
        wr(2'd3, 32'h0000_0004);
        step(5);
        chk_reg("post_rst_once", 2'd3, 32'h0);
        check("post_rst_irq", {31'b0, irq}, 32'h0);
`else
        // Short glitch is filtered, long pulse is accepted
        in_port = 4'hD;
        step(5);
        in_port = 4'hF;
        step(12);
        chk_reg("glitch_data", 2'd0, 32'h0000_000F);
        chk_reg("glitch_edge", 2'd3, 32'h0);
        in_port = 4'hD;
        step(12);
        chk_reg("pulse_data", 2'd0, 32'h0000_000D);
        chk_reg("pulse_edge", 2'd3, 32'h0000_0002);
        in_port = 4'hF;
        step(12);
        chk_reg("pulse_release", 2'd0, 32'h0000_000F);
        chk_reg("pulse_edge_hold", 2'd3, 32'h0000_0002);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_input_pio.md
KEY_INPUT_PIO -- requirements
Module: key_input_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input bits, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: required stable-cycle count per bit; only used when KEY_PIO_DEBOUNCE_EN is defined.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_port  input  WIDTH  asynchronous external inputs, active-low pushbuttons.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-008 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-010 SHALL have port readdata  output  32  Avalon-MM read data, zero-extended above WIDTH.
REQ-011 SHALL have port irq  output  1  level interrupt request, active-high.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer per bit; the synchronized value is "sync".
REQ-013 SHALL derive "clean" from sync (per REQ-030/031) and hold the previous clean value in "clean_d" (1 register).
REQ-014 SHALL define a press event on bit i as clean_d[i]=1 and clean[i]=0 (falling edge).
REQ-015 SHALL provide the register map: addr 0 = data (clean, RO); addr 1 = reserved (reads 0, writes ignored); addr 2 = irq_mask (RW, WIDTH bits); addr 3 = edge_capture (R, write-1-to-clear).
REQ-016 SHALL drive readdata combinationally from address (zero wait states, zero read latency); chipselect is not needed for reads.
REQ-017 SHALL perform a write only when chipselect=1 and write_n=0, in that cycle.
REQ-018 SHALL set edge_capture[i] on the cycle after a press event on bit i, and hold it until cleared.
REQ-019 SHALL clear edge_capture[i] when a write to addr 3 has writedata[i]=1; bits with writedata[i]=0 are unchanged.
REQ-020 SHALL give set priority when a press event and a clear on the same bit occur in the same cycle: the bit ends at 1.
REQ-021 SHALL drive irq = OR over i of (edge_capture[i] AND irq_mask[i]), registered, so irq asserts one cycle after edge_capture or irq_mask changes.
REQ-022 SHALL latch writedata[WIDTH-1:0] into irq_mask on a write to addr 2; upper bits are ignored.
REQ-023 SHALL have a latency from an in_port falling edge to data-register visibility of 2 cycles (debounce disabled), plus 1 cycle to edge_capture and 1 more cycle to irq.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force synchronizer flops, clean, and clean_d to all 1s (released), so no spurious event occurs at reset release.
REQ-025 SHALL reset irq_mask to 0, edge_capture to 0, irq to 0, and all debounce counters to 0.
REQ-026 SHALL discard in-progress debounce counts when reset asserts mid-operation; after release a bit needs a full DEBOUNCE_CYCLES of stability again.
REQ-027 SHALL produce readdata = 0 for addrs 1/2/3 and all-1s (WIDTH bits) for addr 0 during reset.

Configuration
REQ-028 SHALL use macro KEY_PIO_DEBOUNCE_EN to compile the debounce logic in or out.
REQ-029 SHALL, with the macro defined, instantiate one counter per bit of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-030 SHALL, with the macro defined, reset a bit's counter whenever sync[i] equals clean[i]; otherwise increment it, and on reaching DEBOUNCE_CYCLES-1 copy sync[i] to clean[i] and zero the counter; glitches shorter than DEBOUNCE_CYCLES never reach clean.
REQ-031 SHALL, with the macro undefined, set clean = sync (no counters), giving the 2-cycle latency of REQ-023.

Verification
REQ-032 SHALL cover: macro off, reset released, in_port=4'hF, then in_port[2]->0 at cycle 10 -> data reads 4'hB from cycle 12, edge_capture=4'h4 at 13, irq stays 0 (mask 0).
REQ-033 SHALL cover: write irq_mask=4'h4, then press bit 2 -> irq=1 one cycle after edge_capture sets; write 32'h4 to addr 3 -> edge_capture=0, irq=0 one cycle later.
REQ-034 SHALL cover: press event on bit 0 in the same cycle as a write of 32'hF to addr 3 -> edge_capture[0]=1 afterwards; other bits 0.
REQ-035 SHALL cover: macro on, DEBOUNCE_CYCLES=8, 5-cycle low glitch on bit 1 -> data stays 4'hF, edge_capture stays 0; 12-cycle low pulse -> data=4'hD and edge_capture[1]=1.
REQ-036 SHALL cover: reset_n asserted with edge_capture=4'h3, irq_mask=4'hF, a bit held low -> all registers reset per REQ-024/025; after release with the bit still low, exactly one press event is captured.
REQ-037 SHALL cover: reads of addr 1 return 0; a write of 32'hFFFF_FFFF to addr 0 or addr 1 changes no register.
